xc_mask_rng_sched: RTL and testbench

XC_MASK_RNG_SCHED -- requirements
Module: xc_mask_rng_sched

---
 rtl/xc_mask_rng_sched.sv | 177 +++++++++++++++++
 tb/tb_xc_mask_rng_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_mask_rng_sched.sv
// xc_mask_rng_sched
// Masking-randomness scheduler: a 32-bit Galois LFSR fills a small mask
// buffer, and two requesters (remask/arith-mask unit on port 0,
// bool/arith conversion on port 1) draw masks from it under round-robin
// arbitration.
//
// Optional feature macro: XC_MASK_RNG_RESEED_EN
//   defined   -> delivered masks are counted; after RESEED_LIMIT masks all
//                grants stop and reseed_req is raised until a new non-zero
//                seed is accepted.
//   undefined -> reseed_req is tied low and grants are unlimited.
//
// Handshake semantics: a transfer happens in any cycle where valid and
// ready are both high at the rising edge of g_clk. seed_ready is always 1,
// so seed_valid alone is a seed handshake. reqN_ready is combinational
// from reqN_valid and is only ever high when reqN_valid is high; the mask
// is valid on reqN_mask in exactly that cycle and reads 0 otherwise.
module xc_mask_rng_sched #(
    parameter int DEPTH        = 4,
    parameter int RESEED_LIMIT = 1024
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   seed_valid,
    input  logic [31:0]            seed_data,
    output logic                   seed_ready,
    input  logic                   flush,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    output logic [31:0]            req0_mask,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    output logic [31:0]            req1_mask,
    output logic                   seeded,
    output logic                   reseed_req,
    output logic                   dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int          PW   = $clog2(DEPTH);
    localparam int          CW   = PW + 1;
    localparam logic [31:0] POLY = 32'h0040_0007;

    typedef enum logic {
        ST_UNSEEDED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t          state;
    logic [31:0]     lfsr;
    logic [31:0]     lfsr_next;
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            prio;

    logic            seed_load;
    logic            is_run;
    logic            full;
    logic            empty;
    logic            limit_hit;
    logic            can_grant;
    logic            win0;
    logic            grant0;
    logic            grant1;
    logic            pop;
    logic            push;
    logic [31:0]     head;

    assign lfsr_next = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? POLY : 32'h0);

    // A zero seed would lock the LFSR, so it is swallowed without effect.
    assign seed_load = seed_valid && (seed_data != 32'h0);
    assign is_run    = (state == ST_RUN);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];

    // No grants while flushing or reseeding: those cycles discard the buffer.
    assign can_grant = is_run && !empty && !flush && !seed_load && !limit_hit;
    assign win0      = req0_valid && (!req1_valid || !prio);
    assign grant0    = can_grant && win0;
    assign grant1    = can_grant && req1_valid && !win0;
    assign pop       = grant0 || grant1;

    // The generator only produces while its output has somewhere to go.
    assign push      = is_run && !full && !seed_load;

    assign seed_ready = 1'b1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign req0_mask  = grant0 ? head : 32'h0;
    assign req1_mask  = grant1 ? head : 32'h0;
    assign seeded     = is_run;
    assign dbg_state  = state;
    assign dbg_count  = count;

    // Control FSM with LFSR, buffer pointers/occupancy and arbitration pointer.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state  <= ST_UNSEEDED;
            lfsr   <= 32'h0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= 1'b0;
        end else begin
            if (seed_load) begin
                state  <= ST_RUN;
                lfsr   <= seed_data;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    lfsr <= lfsr_next;
                end
                if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                    case ({push, pop})
                        2'b10:   count <= count + CW'(1);
                        2'b01:   count <= count - CW'(1);
                        default: count <= count;
                    endcase
                end
            end
            if (pop) begin
                // The winner yields priority to the other requester.
                prio <= grant0;
            end
        end
    end

    // Mask storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge g_clk) begin
        if (push) begin
            mem[wr_ptr] <= lfsr;
        end
    end

`ifdef XC_MASK_RNG_RESEED_EN
    localparam int DW = $clog2(RESEED_LIMIT + 1);

    logic [DW-1:0] del_cnt;

    assign limit_hit  = (del_cnt == DW'(RESEED_LIMIT));
    assign reseed_req = limit_hit;

    // Count delivered masks; a valid seed restarts the budget.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            del_cnt <= '0;
        end else if (seed_load) begin
            del_cnt <= '0;
        end else if (pop) begin
            del_cnt <= del_cnt + DW'(1);
        end
    end
`else
    logic unused_reseed_limit;

    assign unused_reseed_limit = (RESEED_LIMIT > 0);
    assign limit_hit           = 1'b0;
    assign reseed_req          = 1'b0;
`endif

endmodule

// File: tb/tb_xc_mask_rng_sched.sv
`timescale 1ns/1ps
module tb_xc_mask_rng_sched;

    localparam int          DEPTH = 4;
    localparam int          LIMIT = 3;
    localparam logic [31:0] POLY  = 32'h0040_0007;
`ifdef XC_MASK_RNG_RESEED_EN
    localparam int          N_RR  = 3;
`else
    localparam int          N_RR  = 4;
`endif

    // ---------------- clock / reset ----------------
    logic        g_clk      = 1'b0;
    logic        g_resetn   = 1'b0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed_data  = 32'h0;
    logic        seed_ready;
    logic        flush      = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_mask;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_mask;
    logic        seeded;
    logic        reseed_req;
    logic        dbg_state;
    logic [2:0]  dbg_count;

    int checks   = 0;
    int failures = 0;

    always #5 g_clk = ~g_clk;

    xc_mask_rng_sched #(
        .DEPTH        (DEPTH),
        .RESEED_LIMIT (LIMIT)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_mask  (req0_mask),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_mask  (req1_mask),
        .seeded     (seeded),
        .reseed_req (reseed_req),
        .dbg_state  (dbg_state),
        .dbg_count  (dbg_count)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
    endfunction

    // ---------------- scoreboard ----------------
    // exp_q holds the masks the generator should have buffered, in order.
    logic [31:0] exp_q[$];
    logic [31:0] m_lfsr = 32'h0;
    logic        m_run  = 1'b0;
    logic        m_prio = 1'b0;
    int          m_del  = 0;

    always @(negedge g_clk) begin : monitor
        logic        sl;
        logic        blocked;
        logic        can_pop;
        logic        e_g0;
        logic        e_g1;
        logic        push;
        logic [31:0] head;
        if (!g_resetn) begin
            m_run  = 1'b0;
            m_lfsr = 32'h0;
            m_prio = 1'b0;
            m_del  = 0;
            exp_q.delete();
            check_eq("reset_ctrl", {req0_ready, req1_ready, seeded, reseed_req, seed_ready, dbg_count},
                     {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
            check_eq("reset_masks", {req0_mask, req1_mask}, 64'h0);
        end else begin
            sl = seed_valid && (seed_data != 32'h0);
`ifdef XC_MASK_RNG_RESEED_EN
            blocked = (m_del >= LIMIT);
`else
            blocked = 1'b0;
`endif
            can_pop = m_run && (exp_q.size() != 0) && !flush && !sl && !blocked;
            e_g0    = can_pop && req0_valid && (!req1_valid || !m_prio);
            e_g1    = can_pop && req1_valid && !e_g0;
            head    = (exp_q.size() != 0) ? exp_q[0] : 32'h0;

            check_eq("ctrl", {req0_ready, req1_ready, seeded, reseed_req, seed_ready},
                     {e_g0, e_g1, m_run, blocked, 1'b1});
            check_eq("mask0", req0_mask, e_g0 ? head : 32'h0);
            check_eq("mask1", req1_mask, e_g1 ? head : 32'h0);
            check_eq("count", dbg_count, exp_q.size());

            push = m_run && (exp_q.size() < DEPTH) && !sl;
            if (e_g0 || e_g1) begin
                m_prio = e_g0;
                m_del++;
            end
            if (sl) begin
                m_run  = 1'b1;
                m_lfsr = seed_data;
                m_del  = 0;
                exp_q.delete();
            end else begin
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (e_g0 || e_g1) void'(exp_q.pop_front());
                    if (push) exp_q.push_back(m_lfsr);
                end
                if (push) m_lfsr = lfsr_step(m_lfsr);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        g_resetn = 1'b0;
        tick();
        tick();
        g_resetn = 1'b1;
    endtask

    task automatic drive_seed(input logic [31:0] v);
        seed_valid = 1'b1;
        seed_data  = v;
        tick();
        seed_valid = 1'b0;
        seed_data  = 32'h0;
    endtask

    task automatic expect_grant0(input string tag, input logic [31:0] m);
        @(negedge g_clk);
        check_eq(tag, {req0_ready, req0_mask}, {1'b1, m});
        tick();
    endtask

    task automatic fill_buffer(input logic [31:0] v);
        drive_seed(v);
        repeat (4) tick();
        @(negedge g_clk);
        check_eq("buffer_full", dbg_count, 3'd4);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] rs;
        #1;
        do_reset();

        // Zero seed while unseeded is swallowed: nothing ever granted.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        drive_seed(32'h0);
        repeat (6) begin
            @(negedge g_clk);
            check_eq("zero_seed", {seeded, req0_ready, req1_ready}, 3'b000);
            tick();
        end

        // Seed 1: masks 1,2,4,8 with the first one two cycles after handshake.
        req1_valid = 1'b0;
        drive_seed(32'h1);
        @(negedge g_clk);
        check_eq("latency_t1", req0_ready, 1'b0);
        tick();
        expect_grant0("seq1_m0", 32'h1);
        expect_grant0("seq1_m1", 32'h2);
        expect_grant0("seq1_m2", 32'h4);
`ifdef XC_MASK_RNG_RESEED_EN
        // Budget of 3 spent: everything blocked until a new seed.
        @(negedge g_clk);
        check_eq("limit_block0", {reseed_req, req0_ready, req0_mask}, {1'b1, 1'b0, 32'h0});
        tick();
        req1_valid = 1'b1;
        @(negedge g_clk);
        check_eq("limit_block1", {reseed_req, req0_ready, req1_ready}, 3'b100);
        tick();
        req1_valid = 1'b0;
        drive_seed(32'h5);
        @(negedge g_clk);
        check_eq("reseed_clear", {reseed_req, req0_ready}, 2'b00);
        tick();
        expect_grant0("reseed_mask", 32'h5);
`else
        expect_grant0("seq1_m3", 32'h8);
        @(negedge g_clk);
        check_eq("no_reseed_req", reseed_req, 1'b0);
        tick();
`endif

        // Seed with MSB set exercises the feedback taps.
        drive_seed(32'h8000_0000);
        @(negedge g_clk);
        check_eq("msb_latency", req0_ready, 1'b0);
        tick();
        expect_grant0("msb_m0", 32'h8000_0000);
        expect_grant0("msb_m1", 32'h0040_0007);

        // A single req1 grant hands priority back to req0.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        @(negedge g_clk);
        check_eq("req1_only", {req0_ready, req1_ready}, 2'b01);
        tick();
        req1_valid = 1'b0;

        // Round robin with a full buffer.
        fill_buffer(32'hACE1_0001);
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < N_RR; i++) begin
            @(negedge g_clk);
            check_eq("rr_ready", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            check_eq("rr_idle_mask", (i % 2 == 0) ? req1_mask : req0_mask, 32'h0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Flush with a full buffer and both requesters asking.
        fill_buffer(32'h0BAD_F00D);
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        flush      = 1'b1;
        @(negedge g_clk);
        check_eq("flush_nogrant", {req0_ready, req1_ready, req0_mask, req1_mask}, 66'h0);
        tick();
        flush      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge g_clk);
        check_eq("flush_empty", dbg_count, 3'd0);
        tick();
        @(negedge g_clk);
        check_eq("flush_refill", dbg_count, 3'd1);
        tick();

        // Reset mid-operation drops everything and needs a fresh seed.
        req0_valid = 1'b1;
        repeat (3) tick();
        do_reset();
        @(negedge g_clk);
        check_eq("midreset", {seeded, req0_ready, dbg_count}, 5'd0);
        tick();

        // Random traffic, flushes and reseeds against the scoreboard.
        rs = $urandom | 32'h1;
        drive_seed(rs);
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 15) == 0);
            seed_valid = ($urandom_range(0, 24) == 0);
            seed_data  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        seed_valid = 1'b0;
        seed_data  = 32'h0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
